shift_load_ctrl: RTL and testbench

- Upstream control stage for the 8-bit parallel-load/serial-shift register (`shift_reg`: S_L, s_in, p_in, Q).
- Accepts bytes over a valid/ready handshake and loads each byte into the register with a one-cycle S_L pulse.
- Then drives 8 shift cycles, sampling the register's Q[0] each cycle to produce an LSB-first serial stream with per-bit strobes.
- Sits between the byte-producing datapath and the shift register.

---
 rtl/shift_pkg.sv | 15 +
 rtl/shift_bit_cnt.sv | 32 +++
 rtl/shift_load_ctrl.sv | 116 +++++++++++
 tb/tb_shift_load_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift-register load/shift controller.
// Holds the FSM state enum and the shift register geometry.
package shift_pkg;

    localparam int SR_WIDTH = 8;
    localparam int SR_CNT_W = 3;
    localparam int LAST_BIT = SR_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/shift_bit_cnt.sv
// Bit counter for the serialiser: clear has priority over enable.
// Ports: clk, rst_n (async active-low), i_clr, i_en, o_last (cnt==LAST).
module shift_bit_cnt
    import shift_pkg::*;
#(
    parameter int CNT_W = SR_CNT_W,
    parameter int LAST  = LAST_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_last = (r_cnt == LAST_CNT);

endmodule

// File: rtl/shift_load_ctrl.sv
// Load/shift controller for an 8-bit PISO shift register: accepts bytes
// over valid/ready, pulses S_L for one LOAD cycle, then streams Q[0]
// LSB-first for 8 cycles with bit_valid/bit_last strobes.
// Ports: clk, rst_n, tx_data/tx_valid/tx_ready (byte in), q0 (serial tap),
// S_L/p_in/s_in (to register), bit_out/bit_valid/bit_last, busy.
// Optional: SHIFT_LOAD_CTRL_ROTATE_EN feeds q0 back into s_in during SHIFT
// so the register rotates and holds the loaded byte again after 8 shifts.
module shift_load_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             q0,
    output logic             S_L,
    output logic [WIDTH-1:0] p_in,
    output logic             s_in,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             bit_last,
    output logic             busy
);

    state_t           r_state;
    logic             r_sl;
    logic [WIDTH-1:0] r_p_in;
    logic             w_last;
    logic             w_load;
    logic             w_shift;
    logic             w_cnt_clr;

    assign w_load  = (r_state == LOAD);
    assign w_shift = (r_state == SHIFT);

    // Clear on LOAD and on the final bit so cnt never wraps past 7.
    assign w_cnt_clr = w_load | (w_shift & w_last);

    shift_bit_cnt #(
        .CNT_W (CNT_W),
        .LAST  (WIDTH - 1)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_cnt_clr),
        .i_en   (w_shift),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sl    <= 1'b0;
            r_p_in  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (tx_valid) begin
                        r_p_in  <= tx_data;
                        r_sl    <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_sl    <= 1'b0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    if (w_last) begin
                        if (tx_valid) begin
                            r_p_in  <= tx_data;
                            r_sl    <= 1'b1;
                            r_state <= LOAD;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_sl    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef SHIFT_LOAD_CTRL_ROTATE_EN
    // Feed the tap back in so the register rotates instead of zero-filling.
    assign s_in = w_shift & q0;
`else
    logic r_s_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_in <= 1'b0;
        end else begin
            r_s_in <= 1'b0;
        end
    end

    assign s_in = r_s_in;
`endif

    assign S_L       = r_sl;
    assign p_in      = r_p_in;
    assign tx_ready  = (r_state == IDLE) | (w_shift & w_last);
    assign busy      = w_load | w_shift;
    assign bit_valid = w_shift;
    assign bit_last  = w_shift & w_last;
    assign bit_out   = w_shift & q0;

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Directed testbench for shift_load_ctrl with a behavioural shift register.
// Each scenario task drives stimulus and checks its own results.
module tb_shift_load_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       q0;
    logic       S_L;
    logic [7:0] p_in;
    logic       s_in;
    logic       bit_out;
    logic       bit_valid;
    logic       bit_last;
    logic       busy;

    logic [7:0] sr_q = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural shift_reg: parallel load when S_L, else shift right.
    always @(posedge clk) begin
        if (S_L) sr_q <= p_in;
        else     sr_q <= {s_in, sr_q[7:1]};
    end

    assign q0 = sr_q[0];

    shift_load_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .q0        (q0),
        .S_L       (S_L),
        .p_in      (p_in),
        .s_in      (s_in),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_last  (bit_last),
        .busy      (busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({tx_ready, busy, S_L, bit_valid, bit_last} !== 5'b10000) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d got rdy/busy/sl/bv/bl=%b want 10000",
                         i, {tx_ready, busy, S_L, bit_valid, bit_last});
            end
        end
        n_checks++;
        if (p_in !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_p_in got %h want 00", p_in);
        end
    endtask

    task automatic test_single;
        logic [7:0] d;
        logic [7:0] q_exp;
        d = 8'hA5;
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        n_checks++;
        if ({S_L, p_in, bit_valid, tx_ready, busy} !== {1'b1, d, 3'b001}) begin
            n_fail++;
            $display("FAIL single_load got sl=%b p_in=%h bv=%b rdy=%b busy=%b want 1 %h 0 0 1",
                     S_L, p_in, bit_valid, tx_ready, busy, d);
        end
        tx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if ({bit_valid, bit_out, bit_last, S_L, busy} !==
                {1'b1, d[i], (i == 7), 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL single_bit%0d got bv/bo/bl/sl/busy=%b want %b",
                         i, {bit_valid, bit_out, bit_last, S_L, busy},
                         {1'b1, d[i], (i == 7), 1'b0, 1'b1});
            end
        end
        step();
        n_checks++;
        if ({busy, tx_ready, bit_valid, bit_last, S_L} !== 5'b01000) begin
            n_fail++;
            $display("FAIL single_idle got busy/rdy/bv/bl/sl=%b want 01000",
                     {busy, tx_ready, bit_valid, bit_last, S_L});
        end
`ifdef SHIFT_LOAD_CTRL_ROTATE_EN
        q_exp = 8'hA5;
`else
        q_exp = 8'h00;
`endif
        n_checks++;
        if (sr_q !== q_exp) begin
            n_fail++;
            $display("FAIL single_readback got Q=%h want %h", sr_q, q_exp);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d1;
        logic [7:0] d2;
        d1 = 8'h3C;
        d2 = 8'hFF;
        tx_data  = d1;
        tx_valid = 1'b1;
        step();
        tx_data = d2;
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if ({bit_valid, bit_out, bit_last, tx_ready} !==
                {1'b1, d1[i], (i == 7), (i == 7)}) begin
                n_fail++;
                $display("FAIL b2b_first_bit%0d got bv/bo/bl/rdy=%b want %b",
                         i, {bit_valid, bit_out, bit_last, tx_ready},
                         {1'b1, d1[i], (i == 7), (i == 7)});
            end
        end
        step();
        n_checks++;
        if ({S_L, p_in, bit_valid, busy} !== {1'b1, d2, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_gap got sl=%b p_in=%h bv=%b busy=%b want 1 %h 0 1",
                     S_L, p_in, bit_valid, busy, d2);
        end
        tx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if ({bit_valid, bit_out, bit_last} !== {1'b1, d2[i], (i == 7)}) begin
                n_fail++;
                $display("FAIL b2b_second_bit%0d got bv/bo/bl=%b want %b",
                         i, {bit_valid, bit_out, bit_last}, {1'b1, d2[i], (i == 7)});
            end
        end
        step();
        n_checks++;
        if ({busy, tx_ready, S_L} !== 3'b010) begin
            n_fail++;
            $display("FAIL b2b_idle got busy/rdy/sl=%b want 010", {busy, tx_ready, S_L});
        end
    endtask

    task automatic test_ignore_valid;
        logic [7:0] d;
        d = 8'h96;
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            tx_valid = 1'b0;
            n_checks++;
            if ({bit_valid, bit_out, bit_last, S_L} !== {1'b1, d[i], (i == 7), 1'b0}) begin
                n_fail++;
                $display("FAIL ignore_bit%0d got bv/bo/bl/sl=%b want %b",
                         i, {bit_valid, bit_out, bit_last, S_L},
                         {1'b1, d[i], (i == 7), 1'b0});
            end
            if (i == 3) begin
                tx_data  = 8'h81;
                tx_valid = 1'b1;
                #1;
                n_checks++;
                if (tx_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ignore_ready got %b want 0", tx_ready);
                end
            end
        end
        step();
        n_checks++;
        if ({busy, S_L, tx_ready, p_in} !== {3'b001, d}) begin
            n_fail++;
            $display("FAIL ignore_idle got busy=%b sl=%b rdy=%b p_in=%h want 0 0 1 %h",
                     busy, S_L, tx_ready, p_in, d);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (bit_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre got bv=%b want 1", bit_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bit_valid, busy, S_L, bit_last, bit_out} !== 5'b00000) begin
            n_fail++;
            $display("FAIL midrst_assert got bv/busy/sl/bl/bo=%b want 00000",
                     {bit_valid, busy, S_L, bit_last, bit_out});
        end
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({tx_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL midrst_release got rdy/busy=%b want 10", {tx_ready, busy});
        end
        d = 8'h01;
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        n_checks++;
        if ({S_L, p_in} !== {1'b1, d}) begin
            n_fail++;
            $display("FAIL midrst_load got sl=%b p_in=%h want 1 %h", S_L, p_in, d);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if ({bit_valid, bit_out, bit_last} !== {1'b1, d[i], (i == 7)}) begin
                n_fail++;
                $display("FAIL midrst_bit%0d got bv/bo/bl=%b want %b",
                         i, {bit_valid, bit_out, bit_last}, {1'b1, d[i], (i == 7)});
            end
        end
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle got busy=%b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_valid();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
